// File: rtl/addr_gen_upd_rd.sv
// Read-side sequencer for the LSTM update-parameter stage: sweeps delta/input memories
// (cell -> feature -> timestep) and emits MAC strobes plus delayed gradient write strobes.
module addr_gen_upd_rd #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_CELL   = 8,
  parameter int unsigned NUM_INPUT  = 53,
  parameter int unsigned TIMESTEP   = 7,
  parameter int unsigned DELAY      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_x,
  output logic                  o_valid,
  output logic                  o_acc_clr,
  output logic                  o_acc_last,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned CW = (NUM_CELL  > 1) ? $clog2(NUM_CELL)  : 1;
  localparam int unsigned IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
  localparam int unsigned TW = (TIMESTEP  > 1) ? $clog2(TIMESTEP)  : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_c;
  logic [IW-1:0]     r_i;
  logic [TW-1:0]     r_t;
  logic [DELAY-1:0]  r_dly;

  state_t            w_state_nxt;
  logic [CW-1:0]     w_c_nxt;
  logic [IW-1:0]     w_i_nxt;
  logic [TW-1:0]     w_t_nxt;
  logic [DELAY-1:0]  w_dly_nxt;
  logic              w_issue;
  logic              w_wa_clr;
  logic              w_clr_nxt;
  logic              w_lst_nxt;
  logic              w_wr_en_nxt;
  logic [AW-1:0]     w_ad_nxt;
  logic [AW-1:0]     w_ax_nxt;
  logic [AW-1:0]     w_wa_nxt;

  logic              w_t_wrap;
  logic              w_i_wrap;
  logic              w_c_end;
  logic              w_last_rd;

  assign w_t_wrap  = (r_t == TW'(TIMESTEP - 1));
  assign w_i_wrap  = (r_i == IW'(NUM_INPUT - 1));
  assign w_c_end   = (r_c == CW'(NUM_CELL - 1));
  assign w_last_rd = w_c_end & w_i_wrap & w_t_wrap;

  // Counters hold the indices of the read currently presented on the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_i_nxt     = r_i;
    w_t_nxt     = r_t;
    w_issue     = 1'b0;
    w_wa_clr    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && en) begin
          w_state_nxt = S_RUN;
          w_c_nxt     = '0;
          w_i_nxt     = '0;
          w_t_nxt     = '0;
          w_issue     = 1'b1;
          w_wa_clr    = 1'b1;
        end
      end
      S_RUN: begin
        if (en) begin
          if (w_last_rd) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_issue = 1'b1;
            if (w_t_wrap) begin
              w_t_nxt = '0;
              if (w_i_wrap) begin
                w_i_nxt = '0;
                w_c_nxt = r_c + CW'(1);
              end else begin
                w_i_nxt = r_i + IW'(1);
              end
            end else begin
              w_t_nxt = r_t + TW'(1);
            end
          end
        end
      end
      // Line empty means the final write strobe is on the outputs this cycle.
      S_DRAIN: begin
        if (en && (r_dly == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_clr_nxt = w_issue & (w_t_nxt == '0);
    w_lst_nxt = w_issue & (w_t_nxt == TW'(TIMESTEP - 1));

    // Stage 0 mirrors the ungated last flag so a stall never drops a pending write.
    w_dly_nxt = r_dly;
    if (en) begin
      w_dly_nxt[0] = w_lst_nxt;
      for (int k = 1; k < int'(DELAY); k++) begin
        w_dly_nxt[k] = r_dly[k-1];
      end
    end
    w_wr_en_nxt = en & r_dly[DELAY-1];

    w_ad_nxt = o_addr_d;
    w_ax_nxt = o_addr_x;
    if (w_issue) begin
      w_ad_nxt = AW'(w_t_nxt) * AW'(NUM_CELL)  + AW'(w_c_nxt);
      w_ax_nxt = AW'(w_t_nxt) * AW'(NUM_INPUT) + AW'(w_i_nxt);
    end

    w_wa_nxt = o_wr_addr;
    if (w_wa_clr) begin
      w_wa_nxt = '0;
    end else if (o_wr_en) begin
      w_wa_nxt = o_wr_addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_c        <= '0;
      r_i        <= '0;
      r_t        <= '0;
      r_dly      <= '0;
      o_addr_d   <= '0;
      o_addr_x   <= '0;
      o_valid    <= 1'b0;
      o_acc_clr  <= 1'b0;
      o_acc_last <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_c        <= w_c_nxt;
      r_i        <= w_i_nxt;
      r_t        <= w_t_nxt;
      r_dly      <= w_dly_nxt;
      o_addr_d   <= w_ad_nxt;
      o_addr_x   <= w_ax_nxt;
      o_valid    <= w_issue;
      o_acc_clr  <= w_clr_nxt;
      o_acc_last <= w_lst_nxt;
      o_wr_en    <= w_wr_en_nxt;
      o_wr_addr  <= w_wa_nxt;
      o_busy     <= (w_state_nxt != S_IDLE);
      o_done     <= (w_state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_addr_gen_upd_rd.sv
// Directed bench for addr_gen_upd_rd: small C=2/I=3/T=2/D=3 instance plus a T=1 instance.
module tb_addr_gen_upd_rd;

  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic en = 1'b1;

  logic [AW-1:0] a_ad, a_ax, a_wa, b_ad, b_ax, b_wa;
  logic a_v, a_clr, a_last, a_we, a_busy, a_done;
  logic b_v, b_clr, b_last, b_we, b_busy, b_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addr_gen_upd_rd #(.ADDR_WIDTH(AW), .NUM_CELL(2), .NUM_INPUT(3), .TIMESTEP(2), .DELAY(3)) u_a (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .o_addr_d(a_ad), .o_addr_x(a_ax), .o_valid(a_v), .o_acc_clr(a_clr), .o_acc_last(a_last),
    .o_wr_en(a_we), .o_wr_addr(a_wa), .o_busy(a_busy), .o_done(a_done));

  addr_gen_upd_rd #(.ADDR_WIDTH(AW), .NUM_CELL(2), .NUM_INPUT(3), .TIMESTEP(1), .DELAY(3)) u_b (
    .clk(clk), .rst(rst), .start(start), .en(en),
    .o_addr_d(b_ad), .o_addr_x(b_ax), .o_valid(b_v), .o_acc_clr(b_clr), .o_acc_last(b_last),
    .o_wr_en(b_we), .o_wr_addr(b_wa), .o_busy(b_busy), .o_done(b_done));

  wire [41:0] obs_a = {a_v, a_clr, a_last, a_we, a_busy, a_done, a_ad, a_ax, a_wa};
  wire [41:0] obs_b = {b_v, b_clr, b_last, b_we, b_busy, b_done, b_ad, b_ax, b_wa};

  // Hand-derived baseline trace, index = cycles after the start cycle N.
  int ea_ad   [18] = '{0,0,2,0,2,0,2,1,3,1,3,1,3,3,3,3,3,3};
  int ea_ax   [18] = '{0,0,3,1,4,2,5,0,3,1,4,2,5,5,5,5,5,5};
  int ea_v    [18] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0};
  int ea_clr  [18] = '{0,1,0,1,0,1,0,1,0,1,0,1,0,0,0,0,0,0};
  int ea_last [18] = '{0,0,1,0,1,0,1,0,1,0,1,0,1,0,0,0,0,0};
  int ea_we   [18] = '{0,0,0,0,0,1,0,1,0,1,0,1,0,1,0,1,0,0};
  int ea_wa   [18] = '{0,0,0,0,0,0,1,1,2,2,3,3,4,4,5,5,6,6};
  int ea_busy [18] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
  int ea_done [18] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};

  // T=1 trace: every valid read is both first and last term.
  int eb_ad   [12] = '{0,0,0,0,1,1,1,1,1,1,1,1};
  int eb_ax   [12] = '{0,0,1,2,0,1,2,2,2,2,2,2};
  int eb_v    [12] = '{0,1,1,1,1,1,1,0,0,0,0,0};
  int eb_we   [12] = '{0,0,0,0,1,1,1,1,1,1,0,0};
  int eb_wa   [12] = '{0,0,0,0,0,1,2,3,4,5,6,6};
  int eb_busy [12] = '{0,1,1,1,1,1,1,1,1,1,1,0};
  int eb_done [12] = '{0,0,0,0,0,0,0,0,0,0,1,0};

  function automatic logic [41:0] mk(input int v, input int c, input int l, input int w,
                                     input int b, input int d, input int ad, input int ax,
                                     input int wa);
    return {1'(v), 1'(c), 1'(l), 1'(w), 1'(b), 1'(d), 12'(ad), 12'(ax), 12'(wa)};
  endfunction

  function automatic logic [41:0] base_a(input int k);
    return mk(ea_v[k], ea_clr[k], ea_last[k], ea_we[k], ea_busy[k], ea_done[k],
              ea_ad[k], ea_ax[k], ea_wa[k]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    en = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs_a !== 42'h0) begin
      n_err++;
      $display("FAIL reset_a got=%h want=%h", obs_a, 42'h0);
    end
    n_cmp++;
    if (obs_b !== 42'h0) begin
      n_err++;
      $display("FAIL reset_b got=%h want=%h", obs_b, 42'h0);
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_baseline(input bit with_reset);
    logic [41:0] exp_v;
    if (with_reset) do_reset();
    for (int k = 0; k < 18; k++) begin
      exp_v = base_a(k);
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL baseline k=%0d got=%h want=%h", k, obs_a, exp_v);
      end
      start = (k == 0);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_stall();
    logic [41:0] exp_v;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k < 5)       exp_v = base_a(k);
      else if (k < 7)  exp_v = mk(0, 0, 0, 0, ea_busy[4], ea_done[4], ea_ad[4], ea_ax[4], ea_wa[4]);
      else             exp_v = base_a(k - 2);
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL stall k=%0d got=%h want=%h", k, obs_a, exp_v);
      end
      start = (k == 0);
      en = !(k == 4 || k == 5);
      tick();
    end
    start = 1'b0;
    en = 1'b1;
  endtask

  task automatic test_start_busy();
    logic [41:0] exp_v;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      exp_v = base_a(k);
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL start_busy k=%0d got=%h want=%h", k, obs_a, exp_v);
      end
      start = (k == 0 || k == 6);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [41:0] exp_v;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      exp_v = (k == 9) ? 42'h0 : base_a(k);
      n_cmp++;
      if (obs_a !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid k=%0d got=%h want=%h", k, obs_a, exp_v);
      end
      start = (k == 0);
      rst = (k == 8);
      tick();
    end
    rst = 1'b0;
    start = 1'b0;
    test_baseline(1'b0);
  endtask

  task automatic test_t1();
    logic [41:0] exp_v;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      exp_v = mk(eb_v[k], eb_v[k], eb_v[k], eb_we[k], eb_busy[k], eb_done[k],
                 eb_ad[k], eb_ax[k], eb_wa[k]);
      n_cmp++;
      if (obs_b !== exp_v) begin
        n_err++;
        $display("FAIL t1 k=%0d got=%h want=%h", k, obs_b, exp_v);
      end
      start = (k == 0);
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_baseline(1'b1);
    test_stall();
    test_start_busy();
    test_reset_mid();
    test_t1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
